// File: rtl/fetch_exec_pkg.sv
// fetch_exec_pkg: state encoding and opcode constants shared by the fetch/execute core
package fetch_exec_pkg;
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEMRD  = 3'd4
  } state_t;
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDI = 4'h1;
  localparam logic [3:0] OP_LD  = 4'h2;
  localparam logic [3:0] OP_ST  = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_JMP = 4'h5;
  localparam logic [3:0] OP_JZ  = 4'h6;
  localparam logic [3:0] OP_HLT = 4'hF;
  function automatic logic needs_memrd(input logic [3:0] op);
    return op == OP_LD || op == OP_ADD;
  endfunction
endpackage

// File: rtl/fe_pc.sv
// fe_pc: program counter register; clk/rst, ld_i+ld_val_i load (wins over inc_i), inc_i wraps mod 2^AW, pc_o current value
module fe_pc #(
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld_i,
  input  logic          inc_i,
  input  logic [AW-1:0] ld_val_i,
  output logic [AW-1:0] pc_o
);
  logic [AW-1:0] pc_q;
  always_ff @(posedge clk) begin
    if (rst) pc_q <= '0;
    else if (ld_i) pc_q <= ld_val_i;
    else if (inc_i) pc_q <= pc_q + AW'(1);
  end
  assign pc_o = pc_q;
endmodule

// File: rtl/fetch_exec_core.sv
// fetch_exec_core: accumulator core with FETCH/DECODE/EXEC/MEMRD sequencing over a synchronous-read memory.
// Ports: clk, rst (sync, active-high), run/halt control, mem_addr/mem_wdata/mem_we/mem_rdata memory bus,
// pc/ir/acc/carry architectural state, busy (not IDLE). Optional single-step input step when FETCH_EXEC_STEP_EN is defined.
module fetch_exec_core
  import fetch_exec_pkg::*;
#(
  parameter int AW = 12,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  input  logic          halt,
`ifdef FETCH_EXEC_STEP_EN
  input  logic          step,
`endif
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata,
  output logic [AW-1:0] pc,
  output logic [DW-1:0] ir,
  output logic [DW-1:0] acc,
  output logic          carry,
  output logic          busy
);
  state_t        state_q, state_d;
  logic [DW-1:0] ir_q, ir_d, acc_q, acc_d;
  logic          carry_q, carry_d, step_q, step_d;
  logic [3:0]    op;
  logic [AW-1:0] addr, pc_q;
  logic          step_in, go, stop, mem_op, pc_ld;
  logic [DW:0]   sum;
`ifdef FETCH_EXEC_STEP_EN
  assign step_in = step;
`else
  assign step_in = 1'b0;
`endif
  assign op = ir_q[DW-1:DW-4];
  if (AW > DW-4) begin : g_zx
    assign addr = {{(AW-DW+4){1'b0}}, ir_q[DW-5:0]};
  end else begin : g_tr
    assign addr = ir_q[AW-1:0];
  end
  assign go     = (run || step_in) && !halt;
  // a stepped instruction always returns to IDLE, whatever run says
  assign stop   = halt || op == OP_HLT || step_q;
  assign mem_op = op == OP_LD || op == OP_ADD || op == OP_ST;
  assign pc_ld  = state_q == S_EXEC && (op == OP_JMP || (op == OP_JZ && acc_q == '0));
  assign sum    = {1'b0, acc_q} + {1'b0, mem_rdata};
  fe_pc #(.AW(AW)) u_pc (
    .clk     (clk),
    .rst     (rst),
    .ld_i    (pc_ld),
    .inc_i   (state_q == S_DECODE),
    .ld_val_i(addr),
    .pc_o    (pc_q)
  );
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    step_d  = step_q;
    case (state_q)
      S_IDLE: begin
        state_d = go ? S_FETCH : S_IDLE;
        step_d  = go ? step_in : step_q;
      end
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        ir_d    = mem_rdata;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        acc_d   = op == OP_LDI ? {4'b0, ir_q[DW-5:0]} : acc_q;
        state_d = needs_memrd(op) ? S_MEMRD : stop ? S_IDLE : S_FETCH;
      end
      S_MEMRD: begin
        acc_d   = op == OP_ADD ? sum[DW-1:0] : mem_rdata;
        carry_d = op == OP_ADD ? sum[DW] : carry_q;
        state_d = stop ? S_IDLE : S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      step_q  <= step_d;
    end
  end
  assign mem_addr  = (state_q == S_EXEC && mem_op) ? addr : pc_q;
  assign mem_wdata = acc_q;
  // gated by rst so a reset landing on the store cycle drops the write
  assign mem_we    = state_q == S_EXEC && op == OP_ST && !rst;
  assign pc        = pc_q;
  assign ir        = ir_q;
  assign acc       = acc_q;
  assign carry     = carry_q;
  assign busy      = state_q != S_IDLE;
endmodule

// File: tb/tb_fetch_exec_core.sv
// tb_fetch_exec_core: directed programs with hand-computed results for fetch_exec_core
module tb_fetch_exec_core;
  logic        clk = 1'b0;
  logic        rst = 1'b1, run = 1'b0, halt = 1'b0, step = 1'b0;
  logic [11:0] mem_addr, pc;
  logic [15:0] mem_wdata, mem_rdata, ir, acc;
  logic        mem_we, carry, busy;
  logic [15:0] mem [0:4095];
  logic        clr = 1'b0, ld_en = 1'b0;
  logic [11:0] ld_a = '0, last_a = '0;
  logic [15:0] ld_d = '0, last_d = '0;
  int          wr_cnt = 0, total = 0, bad = 0, n = 0, w0 = 0;

  always #5 clk = ~clk;

  fetch_exec_core #(.AW(12), .DW(16)) dut (
    .clk(clk), .rst(rst), .run(run), .halt(halt),
`ifdef FETCH_EXEC_STEP_EN
    .step(step),
`endif
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .pc(pc), .ir(ir), .acc(acc), .carry(carry), .busy(busy)
  );

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 4096; i++) mem[i] <= '0;
    end else if (ld_en) mem[ld_a] <= ld_d;
    else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
      wr_cnt <= wr_cnt + 1;
      last_a <= mem_addr;
      last_d <= mem_wdata;
    end
    mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_prog();
    rst = 1'b1; run = 1'b0; halt = 1'b0; step = 1'b0; clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic poke(input logic [11:0] a, input logic [15:0] d);
    ld_en = 1'b1; ld_a = a; ld_d = d;
    tick();
    ld_en = 1'b0;
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (busy && cyc < 200) begin
      tick();
      cyc++;
    end
    if (busy) chk("timeout", 32'(busy), 32'd0);
  endtask

  task automatic go_run(output int cyc);
    rst = 1'b0;
    w0 = wr_cnt;
    run = 1'b1;
    tick();
    run = 1'b0;
    wait_idle(cyc);
  endtask

  initial begin
    // LDI then HLT, plus reset state
    begin_prog();
    poke(12'h000, 16'h1055);
    poke(12'h001, 16'hF000);
    chk("rst_pc", 32'(pc), 0);
    chk("rst_acc", 32'(acc), 0);
    chk("rst_ir", 32'(ir), 0);
    chk("rst_carry", 32'(carry), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_we", 32'(mem_we), 0);
    go_run(n);
    chk("ldi_cycles", 32'(n), 6);
    chk("ldi_acc", 32'(acc), 32'h0055);
    chk("ldi_pc", 32'(pc), 2);
    chk("ldi_busy", 32'(busy), 0);

    // LD / ADD with carry / ST
    begin_prog();
    poke(12'h000, 16'h1010);
    poke(12'h001, 16'h2020);
    poke(12'h002, 16'h4021);
    poke(12'h003, 16'h3022);
    poke(12'h004, 16'hF000);
    poke(12'h020, 16'hFFFF);
    poke(12'h021, 16'h0002);
    go_run(n);
    chk("arith_cycles", 32'(n), 17);
    chk("arith_acc", 32'(acc), 32'h0001);
    chk("arith_carry", 32'(carry), 1);
    chk("arith_wr_cnt", 32'(wr_cnt - w0), 1);
    chk("arith_wr_addr", 32'(last_a), 32'h022);
    chk("arith_wr_data", 32'(last_d), 32'h0001);
    chk("arith_mem22", 32'(mem[12'h022]), 32'h0001);

    // JZ taken, stopped by halt right after it
    begin_prog();
    poke(12'h000, 16'h6100);
    rst = 1'b0;
    run = 1'b1;
    tick();
    run = 1'b0; halt = 1'b1;
    wait_idle(n);
    chk("jz_taken_pc", 32'(pc), 32'h100);
    chk("jz_taken_cycles", 32'(n), 3);
    run = 1'b1;
    repeat (3) tick();
    chk("run_halt_idle", 32'(busy), 0);

    // JZ not taken: falls through to HLT at address 2
    begin_prog();
    poke(12'h000, 16'h1001);
    poke(12'h001, 16'h6100);
    poke(12'h002, 16'hF000);
    poke(12'h100, 16'hF000);
    go_run(n);
    chk("jz_nt_pc", 32'(pc), 3);
    chk("jz_nt_acc", 32'(acc), 1);

    // PC wrap: JMP to 0xFFF, then NOP at 0xFFF wraps pc to 0
    begin_prog();
    poke(12'h000, 16'h5FFF);
    rst = 1'b0;
    run = 1'b1;
    tick();
    run = 1'b0; halt = 1'b1;
    wait_idle(n);
    chk("jmp_pc", 32'(pc), 32'hFFF);
    halt = 1'b0; run = 1'b1;
    tick();
    run = 1'b0; halt = 1'b1;
    wait_idle(n);
    chk("wrap_pc", 32'(pc), 0);

    // halt during LD EXEC: MEMRD still completes
    begin_prog();
    poke(12'h000, 16'h2020);
    poke(12'h001, 16'h1077);
    poke(12'h020, 16'h1234);
    rst = 1'b0;
    run = 1'b1;
    tick();
    run = 1'b0;
    tick();
    tick();
    halt = 1'b1;
    chk("ld_exec_addr", 32'(mem_addr), 32'h020);
    tick();
    chk("ld_memrd_busy", 32'(busy), 1);
    tick();
    chk("halt_ld_busy", 32'(busy), 0);
    chk("halt_ld_acc", 32'(acc), 32'h1234);
    repeat (4) tick();
    chk("halt_no_fetch_pc", 32'(pc), 1);
    halt = 1'b0;

    // reset on ST EXEC cycle: no write, all cleared
    begin_prog();
    poke(12'h000, 16'h1042);
    poke(12'h001, 16'h3030);
    rst = 1'b0;
    w0 = wr_cnt;
    run = 1'b1;
    tick();
    run = 1'b0;
    repeat (5) tick();
    chk("st_we", 32'(mem_we), 1);
    chk("st_addr", 32'(mem_addr), 32'h030);
    chk("st_wdata", 32'(mem_wdata), 32'h0042);
    rst = 1'b1;
    tick();
    chk("rst_st_we", 32'(mem_we), 0);
    chk("rst_st_pc", 32'(pc), 0);
    chk("rst_st_acc", 32'(acc), 0);
    chk("rst_st_ir", 32'(ir), 0);
    chk("rst_st_busy", 32'(busy), 0);
    rst = 1'b0; run = 1'b1; halt = 1'b1;
    repeat (3) tick();
    chk("rst_st_runhalt", 32'(busy), 0);
    chk("rst_st_nowrite", 32'(wr_cnt - w0), 0);
    chk("rst_st_mem30", 32'(mem[12'h030]), 0);
    run = 1'b0; halt = 1'b0;

`ifdef FETCH_EXEC_STEP_EN
    begin_prog();
    poke(12'h000, 16'h1011);
    poke(12'h001, 16'h1022);
    poke(12'h002, 16'hF000);
    rst = 1'b0;
    step = 1'b1;
    tick();
    step = 1'b0;
    wait_idle(n);
    chk("step1_pc", 32'(pc), 1);
    chk("step1_acc", 32'(acc), 32'h0011);
    repeat (10) begin
      tick();
      chk("step_gap_busy", 32'(busy), 0);
    end
    step = 1'b1;
    tick();
    step = 1'b0;
    wait_idle(n);
    chk("step2_pc", 32'(pc), 2);
    chk("step2_acc", 32'(acc), 32'h0022);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
